// File: rtl/pipe_stage_reg.sv
// Pipeline stage register with a valid/ready handshake and a two-entry skid buffer.
// Empty stages present a zero control bundle so downstream only ever sees a NOP.
module pipe_stage_reg #(
    parameter int CTRL_W   = 12,
    parameter int DATA_W   = 32,
    parameter int NUM_DATA = 3,
    parameter int AUX_W    = 35,
    parameter int CNT_W    = 16
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [CTRL_W-1:0]          in_ctrl,
    input  logic [NUM_DATA*DATA_W-1:0] in_data,
    input  logic [AUX_W-1:0]           in_aux,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [CTRL_W-1:0]          out_ctrl,
    output logic [NUM_DATA*DATA_W-1:0] out_data,
    output logic [AUX_W-1:0]           out_aux,
    input  logic                       flush,
    output logic [1:0]                 occupancy,
    output logic [CNT_W-1:0]           stall_cnt,
    output logic [CNT_W-1:0]           flush_cnt
);

    localparam int DW    = NUM_DATA * DATA_W;
    localparam int PAY_W = CTRL_W + DW + AUX_W;

    localparam logic [1:0] EMPTY = 2'd0;
    localparam logic [1:0] ONE   = 2'd1;
    localparam logic [1:0] FULL  = 2'd2;

    logic [1:0]       state_reg, state_next;
    logic [PAY_W-1:0] main_reg, skid_reg;
    logic [PAY_W-1:0] in_payload;
    logic [CNT_W-1:0] stall_cnt_reg, flush_cnt_reg;
    logic             in_fire, out_fire;
    logic             load_main_in, load_main_skid, load_skid;

    assign in_payload = {in_ctrl, in_data, in_aux};

    // Handshake outputs depend on state only, so out_ready never reaches in_ready combinationally.
    assign in_ready  = (state_reg != FULL);
    assign out_valid = (state_reg != EMPTY);
    assign in_fire   = in_valid & in_ready;
    assign out_fire  = out_valid & out_ready;
    assign occupancy = state_reg;

    always_comb begin
        state_next     = state_reg;
        load_main_in   = 1'b0;
        load_main_skid = 1'b0;
        load_skid      = 1'b0;
        case (state_reg)
            EMPTY: begin
                if (in_fire) begin
                    load_main_in = 1'b1;
                    state_next   = ONE;
                end
            end
            ONE: begin
                if (in_fire && out_fire) begin
                    load_main_in = 1'b1;
                end else if (in_fire) begin
                    load_skid  = 1'b1;
                    state_next = FULL;
                end else if (out_fire) begin
                    state_next = EMPTY;
                end
            end
            FULL: begin
                if (out_fire) begin
                    load_main_skid = 1'b1;
                    state_next     = ONE;
                end
            end
            default: state_next = EMPTY;
        endcase
        // Flush wins: anything accepted this cycle is discarded along with held entries.
        if (flush) begin
            state_next     = EMPTY;
            load_main_in   = 1'b0;
            load_main_skid = 1'b0;
            load_skid      = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= EMPTY;
            main_reg  <= '0;
            skid_reg  <= '0;
        end else begin
            state_reg <= state_next;
            if (load_main_in) begin
                main_reg <= in_payload;
            end else if (load_main_skid) begin
                main_reg <= skid_reg;
            end
            if (load_skid) begin
                skid_reg <= in_payload;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt_reg <= '0;
            flush_cnt_reg <= '0;
        end else begin
            if (out_valid && !out_ready && (stall_cnt_reg != {CNT_W{1'b1}})) begin
                stall_cnt_reg <= stall_cnt_reg + 1'b1;
            end
            if (flush && (state_reg != EMPTY) && (flush_cnt_reg != {CNT_W{1'b1}})) begin
                flush_cnt_reg <= flush_cnt_reg + 1'b1;
            end
        end
    end

    assign stall_cnt = stall_cnt_reg;
    assign flush_cnt = flush_cnt_reg;

    // Control is the bubble carrier; data and aux simply hold their last value when empty.
    assign out_ctrl = out_valid ? main_reg[PAY_W-1 -: CTRL_W] : '0;
    assign out_aux  = main_reg[AUX_W-1:0];

    genvar gi;
    generate
        for (gi = 0; gi < NUM_DATA; gi++) begin : g_out_word
            assign out_data[gi*DATA_W +: DATA_W] = main_reg[AUX_W + gi*DATA_W +: DATA_W];
        end
    endgenerate

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Scoreboard bench for pipe_stage_reg: accepted payloads are queued, delivered ones popped and compared.
module tb_pipe_stage_reg;

    localparam int CTRL_W   = 12;
    localparam int DATA_W   = 32;
    localparam int NUM_DATA = 3;
    localparam int AUX_W    = 35;
    localparam int CNT_W    = 4;
    localparam int DW       = NUM_DATA * DATA_W;

    typedef struct packed {
        logic [CTRL_W-1:0] ctrl;
        logic [DW-1:0]     data;
        logic [AUX_W-1:0]  aux;
    } pay_t;

    logic              clk;
    logic              rst_n;
    logic              in_valid;
    logic              in_ready;
    logic [CTRL_W-1:0] in_ctrl;
    logic [DW-1:0]     in_data;
    logic [AUX_W-1:0]  in_aux;
    logic              out_valid;
    logic              out_ready;
    logic [CTRL_W-1:0] out_ctrl;
    logic [DW-1:0]     out_data;
    logic [AUX_W-1:0]  out_aux;
    logic              flush;
    logic [1:0]        occupancy;
    logic [CNT_W-1:0]  stall_cnt;
    logic [CNT_W-1:0]  flush_cnt;

    pay_t          sb[$];
    int            n_cmp;
    int            n_err;
    int            stall_m;
    int            flush_m;
    logic [DW-1:0] last_data;

    pipe_stage_reg #(
        .CTRL_W  (CTRL_W),
        .DATA_W  (DATA_W),
        .NUM_DATA(NUM_DATA),
        .AUX_W   (AUX_W),
        .CNT_W   (CNT_W)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_ctrl  (in_ctrl),
        .in_data  (in_data),
        .in_aux   (in_aux),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_ctrl (out_ctrl),
        .out_data (out_data),
        .out_aux  (out_aux),
        .flush    (flush),
        .occupancy(occupancy),
        .stall_cnt(stall_cnt),
        .flush_cnt(flush_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Monitor: inputs change only just after posedge, so negedge sees this cycle's handshake.
    always @(negedge clk) begin
        if (rst_n) begin
            int   size;
            bit   m_in_fire;
            pay_t p;
            size = sb.size();
            check("occupancy", 128'(occupancy), 128'(size));
            check("in_ready", 128'(in_ready), 128'(size < 2));
            check("out_valid", 128'(out_valid), 128'(size > 0));
            check("stall_cnt", 128'(stall_cnt), 128'(stall_m));
            check("flush_cnt", 128'(flush_cnt), 128'(flush_m));
            if (size == 0) begin
                check("bubble_ctrl", 128'(out_ctrl), 128'(0));
            end else begin
                p = sb[0];
                check("out_ctrl", 128'(out_ctrl), 128'(p.ctrl));
                check("out_data", 128'(out_data), 128'(p.data));
                check("out_aux", 128'(out_aux), 128'(p.aux));
                if (out_ready) begin
                    $display("deliver ctrl=%03h occ=%0d stall=%0d", p.ctrl, size, stall_cnt);
                    last_data = p.data;
                    void'(sb.pop_front());
                end else if (stall_m < (1 << CNT_W) - 1) begin
                    stall_m++;
                end
            end
            m_in_fire = in_valid && (size < 2);
            if (flush) begin
                if (size > 0 && flush_m < (1 << CNT_W) - 1) flush_m++;
                sb.delete();
            end else if (m_in_fire) begin
                p.ctrl = in_ctrl;
                p.data = in_data;
                p.aux  = in_aux;
                sb.push_back(p);
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Presents one payload and holds it until the stage takes it (bounded).
    task automatic send(input logic [CTRL_W-1:0] c);
        bit ok;
        ok       = 1'b0;
        in_ctrl  = c;
        in_data  = {$urandom(), $urandom(), $urandom()};
        in_aux   = AUX_W'({$urandom(), $urandom()});
        in_valid = 1'b1;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            ok = in_ready;
            @(posedge clk);
            #1;
            if (ok) break;
        end
        in_valid = 1'b0;
        check("send_accept", 128'(ok), 128'(1));
    endtask

    task automatic check_reset_values();
        check("rst_in_ready", 128'(in_ready), 128'(1));
        check("rst_out_valid", 128'(out_valid), 128'(0));
        check("rst_occupancy", 128'(occupancy), 128'(0));
        check("rst_out_ctrl", 128'(out_ctrl), 128'(0));
        check("rst_out_data", 128'(out_data), 128'(0));
        check("rst_out_aux", 128'(out_aux), 128'(0));
        check("rst_stall_cnt", 128'(stall_cnt), 128'(0));
        check("rst_flush_cnt", 128'(flush_cnt), 128'(0));
    endtask

    // Asserts reset mid-cycle and checks the asynchronous response before any clock edge.
    task automatic reset_mid_cycle();
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        sb.delete();
        stall_m   = 0;
        flush_m   = 0;
        last_data = '0;
        #1;
        check_reset_values();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        n_cmp     = 0;
        n_err     = 0;
        stall_m   = 0;
        flush_m   = 0;
        last_data = '0;
        in_valid  = 1'b0;
        in_ctrl   = '0;
        in_data   = '0;
        in_aux    = '0;
        out_ready = 1'b0;
        flush     = 1'b0;
        rst_n     = 1'b1;
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_values();
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Streaming, then three idle cycles of bubbles
        out_ready = 1'b1;
        send(12'h0A5);
        send(12'h0A6);
        send(12'h0A7);
        tick(4);
        @(negedge clk);
        check("bubble_data_hold", 128'(out_data), 128'(last_data));
        check("stream_stall_cnt", 128'(stall_cnt), 128'(0));
        tick(1);

        // Back-pressure: A and B fill the stage, C waits upstream
        out_ready = 1'b0;
        send(12'h001);
        send(12'h002);
        in_ctrl  = 12'h003;
        in_valid = 1'b1;
        tick(3);
        @(negedge clk);
        check("bp_occupancy", 128'(occupancy), 128'(2));
        check("bp_in_ready", 128'(in_ready), 128'(0));
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        send(12'h003);
        tick(4);

        // Flush while FULL with C offered in the same cycle
        reset_mid_cycle();
        out_ready = 1'b0;
        send(12'h00A);
        send(12'h00B);
        in_ctrl  = 12'h00C;
        in_valid = 1'b1;
        flush    = 1'b1;
        tick(1);
        flush    = 1'b0;
        in_valid = 1'b0;
        @(negedge clk);
        check("flush_out_valid", 128'(out_valid), 128'(0));
        check("flush_out_ctrl", 128'(out_ctrl), 128'(0));
        check("flush_occupancy", 128'(occupancy), 128'(0));
        check("flush_in_ready", 128'(in_ready), 128'(1));
        check("flush_cnt_one", 128'(flush_cnt), 128'(1));
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        tick(3);

        // Asynchronous reset while FULL
        out_ready = 1'b0;
        send(12'h011);
        send(12'h012);
        reset_mid_cycle();
        tick(2);

        // Stall counter saturation at 2^CNT_W-1
        out_ready = 1'b0;
        send(12'h055);
        tick(20);
        @(negedge clk);
        check("stall_saturated", 128'(stall_cnt), 128'(15));
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        tick(3);
        check("scoreboard_empty", 128'(sb.size()), 128'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/pipe_stage_reg.md
# pipe_stage_reg

Parametrised ID/EX-style pipeline stage register with a valid/ready handshake, a two-entry skid buffer, flush, and automatic bubble insertion. It sits between any two processor pipeline stages (first use: decode → execute) and carries a control bundle, N data words and an auxiliary field. A stall in the downstream stage back-pressures upstream without losing data. Control is forced to zero whenever the stage is empty, so downstream logic only ever sees a NOP.

## Interface
Parameters:
- CTRL_W, 12 — control bundle width (RegDst, Branch, MemRead, ALUOp, …)
- DATA_W, 32 — width of one data word
- NUM_DATA, 3 — number of data words (e.g. rs data, rt data, sign-extended immediate)
- AUX_W, 35 — auxiliary field width (register numbers, short address, 10-bit immediate)
- CNT_W, 16 — width of the performance counters

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous, active-low reset
- in_valid  in  1  upstream payload valid
- in_ready  out  1  stage can accept a payload
- in_ctrl  in  CTRL_W  control bundle
- in_data  in  NUM_DATA*DATA_W  data words; word k is bits [k*DATA_W +: DATA_W]
- in_aux  in  AUX_W  auxiliary field
- out_valid  out  1  payload valid to downstream
- out_ready  in  1  downstream accepts the payload
- out_ctrl  out  CTRL_W  control bundle; 0 when out_valid=0
- out_data  out  NUM_DATA*DATA_W  data words
- out_aux  out  AUX_W  auxiliary field
- flush  in  1  kill all held payloads (branch mispredict/jump)
- occupancy  out  2  entries held (0..2)
- stall_cnt  out  CNT_W  cycles with out_valid=1 and out_ready=0, saturating
- flush_cnt  out  CNT_W  flush cycles that killed ≥1 entry, saturating

## Operation
- in_fire = in_valid & in_ready; out_fire = out_valid & out_ready.
- Storage: main entry (drives the outputs) and skid entry. Each entry holds ctrl, data and aux.
- States: EMPTY (occ 0), ONE (occ 1), FULL (occ 2). in_ready = (state != FULL). out_valid = (state != EMPTY). Both depend on state only; no combinational path from out_ready.
- EMPTY: in_fire → load main, go to ONE.
- ONE:
  - in_fire & out_fire → main ← input, stay in ONE.
  - in_fire only → skid ← input, go to FULL.
  - out_fire only → go to EMPTY.
  - neither → hold.
- FULL: out_fire → main ← skid, go to ONE. Otherwise hold. No input is accepted.
- flush=1 has priority over everything: next state EMPTY. An in_fire in the same cycle is discarded. An out_fire in the same cycle still counts as delivered to downstream.
- Bubble: out_ctrl = out_valid ? main.ctrl : 0. out_data and out_aux hold their last values when empty; the bench must not check them then.
- Counters saturate at 2^CNT_W−1 and never wrap. stall_cnt increments on out_valid & ~out_ready. flush_cnt increments on flush & (state != EMPTY).

## Timing
- Reset (rst_n=0, asynchronous): state EMPTY, so in_ready=1, out_valid=0 and occupancy=0. out_ctrl=0, out_data=0, out_aux=0, stall_cnt=0, flush_cnt=0. The stage is usable from the first rising edge after rst_n deasserts.
- Latency: 1 cycle from in_fire to out_valid with the payload.
- Throughput: 1 payload/cycle while out_ready=1.
- in_ready falls on the edge that fills the skid entry. It rises on the edge after the first out_fire in FULL.
- Flush takes effect on the next edge: out_valid=0 and in_ready=1 the following cycle.
- Reset asserted mid-transfer drops all entries immediately; counters clear.
- Ordering is strictly FIFO; no payload is duplicated or lost except by flush.

## Test plan
- Streaming: out_ready=1; send ctrl 0x0A5, 0x0A6, 0x0A7 on consecutive cycles → the same values appear on out_ctrl one cycle later, back-to-back; stall_cnt=0.
- Back-pressure: out_ready=0 and send A=0x001 then B=0x002 → occupancy 2, in_ready=0, C=0x003 held upstream. Raise out_ready → out_ctrl shows A, B, C in order; stall_cnt equals the number of held cycles.
- Flush: in FULL holding A and B, pulse flush together with in_valid carrying C → next cycle out_valid=0, out_ctrl=0, occupancy=0, flush_cnt=1; C never appears.
- Bubble: idle input for 3 cycles after the last payload drains → out_ctrl=0 throughout; out_data holds its last value.
- Async reset: assert rst_n=0 mid-cycle while FULL → out_valid=0 and in_ready=1 immediately, without waiting for a clock edge; all outputs and counters are 0.
- Saturation: with CNT_W=4, hold out_valid=1 and out_ready=0 for 20 cycles → stall_cnt stops at 15.
